// File: rtl/uart_ctrl.sv
// ============================================================================
//  Module   : uart_ctrl
//  Purpose  : Sequencer between the mem stage and the external UART chip.
//             Turns single-cycle byte read/write requests into the chip's
//             active-low wrn/rdn strobe protocol with fixed setup, pulse and
//             hold widths. Drives the low byte of the shared RAM1 data bus
//             only while a write is in progress.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    uarti_clk         clock (50 MHz board clock)
//    uarti_rst         synchronous reset, active low
//    uarti_wr_req      write request, sampled in IDLE only
//    uarti_wr_data     byte to send, captured with uarti_wr_req
//    uarti_rd_req      read request, sampled in IDLE only
//    uarto_rd_data     last byte read from the chip
//    uarto_done        one-cycle completion pulse
//    uarto_busy        sequencer is not idle
//    uarto_writeable   idle and transmitter empty (synchronized status)
//    uarto_readable    idle and receive data ready (synchronized status)
//    uarti_tbre/tsre/data_ready  raw asynchronous chip status
//    uarto_wrn/rdn     chip strobes, active low
//    uarto_bus_oe      tristate enable for ram1_data_bus[7:0]
//    uarto_bus_data    byte driven while uarto_bus_oe is high
//    uarti_bus_data    ram1_data_bus[7:0] as seen by the chip side
// ============================================================================
`default_nettype none

module uart_ctrl #(
    parameter int WR_SETUP = 2,
    parameter int WR_PULSE = 3,
    parameter int WR_HOLD  = 3,
    parameter int RD_PULSE = 3
) (
    input  logic       uarti_clk,
    input  logic       uarti_rst,
    input  logic       uarti_wr_req,
    input  logic [7:0] uarti_wr_data,
    input  logic       uarti_rd_req,
    output logic [7:0] uarto_rd_data,
    output logic       uarto_done,
    output logic       uarto_busy,
    output logic       uarto_writeable,
    output logic       uarto_readable,
    input  logic       uarti_tbre,
    input  logic       uarti_tsre,
    input  logic       uarti_data_ready,
    output logic       uarto_wrn,
    output logic       uarto_rdn,
    output logic       uarto_bus_oe,
    output logic [7:0] uarto_bus_data,
    input  logic [7:0] uarti_bus_data
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_SETUP   = 3'd1,
        S_W_PULSE   = 3'd2,
        S_W_HOLD    = 3'd3,
        S_W_WAIT    = 3'd4,
        S_R_PULSE   = 3'd5,
        S_R_RECOVER = 3'd6
    } state_t;

    localparam logic [2:0] SETUP_LOAD = 3'(WR_SETUP - 1);
    localparam logic [2:0] PULSE_LOAD = 3'(WR_PULSE - 1);
    localparam logic [2:0] RD_LOAD    = 3'(RD_PULSE - 1);
    // The strobe flops lag the state register by one edge, so wrn actually
    // rises one cycle after W_HOLD is entered. Loading the full WR_HOLD value
    // makes the hold span WR_HOLD cycles measured from that visible rising
    // edge. This value also marks the first W_HOLD cycle for bus_oe.
    localparam logic [2:0] HOLD_LOAD  = 3'(WR_HOLD);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       wrn_q, wrn_d;
    logic       rdn_q, rdn_d;
    logic       oe_q, oe_d;
    logic       done_q, done_d;
    logic [7:0] bus_data_q, bus_data_d;
    logic [7:0] rd_data_q, rd_data_d;

    // Status synchronizers, bit order {tbre, tsre, data_ready}
    logic [2:0] sync1_q, sync2_q;
    logic       tbre_s, tsre_s, dr_s;

    assign tbre_s = sync2_q[2];
    assign tsre_s = sync2_q[1];
    assign dr_s   = sync2_q[0];

    always_ff @(posedge uarti_clk) begin
        if (!uarti_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            wrn_q      <= 1'b1;
            rdn_q      <= 1'b1;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            bus_data_q <= 8'd0;
            rd_data_q  <= 8'd0;
            sync1_q    <= 3'd0;
            sync2_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wrn_q      <= wrn_d;
            rdn_q      <= rdn_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
            bus_data_q <= bus_data_d;
            rd_data_q  <= rd_data_d;
            sync1_q    <= {uarti_tbre, uarti_tsre, uarti_data_ready};
            sync2_q    <= sync1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        bus_data_d = bus_data_q;
        rd_data_d  = rd_data_q;

        // Strobes and enable are decoded from the current state only, so no
        // request input ever reaches them combinationally.
        wrn_d = (state_q != S_W_PULSE);
        rdn_d = (state_q != S_R_PULSE);
        oe_d  = (state_q == S_W_SETUP) || (state_q == S_W_PULSE) ||
                ((state_q == S_W_HOLD) && (cnt_q == HOLD_LOAD));

        case (state_q)
            S_IDLE: begin
                // Read wins over a simultaneous write: receive data can be
                // overrun, the dropped write is simply re-issued.
                if (uarti_rd_req && dr_s) begin
                    state_d = S_R_PULSE;
                    cnt_d   = RD_LOAD;
                end else if (uarti_wr_req) begin
                    state_d    = S_W_SETUP;
                    cnt_d      = SETUP_LOAD;
                    bus_data_d = uarti_wr_data;
                end
            end
            S_W_SETUP: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_W_PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_W_PULSE: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_W_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_W_HOLD: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_W_WAIT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_W_WAIT: begin
                if (tbre_s && tsre_s) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_R_PULSE: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_R_RECOVER;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_R_RECOVER: begin
                // rdn is still low during this cycle; capture as it rises.
                state_d   = S_IDLE;
                done_d    = 1'b1;
                rd_data_d = uarti_bus_data;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign uarto_wrn       = wrn_q;
    assign uarto_rdn       = rdn_q;
    assign uarto_bus_oe    = oe_q;
    assign uarto_bus_data  = bus_data_q;
    assign uarto_rd_data   = rd_data_q;
    assign uarto_done      = done_q;
    assign uarto_busy      = (state_q != S_IDLE);
    assign uarto_writeable = (state_q == S_IDLE) && tbre_s && tsre_s;
    assign uarto_readable  = (state_q == S_IDLE) && dr_s;

endmodule

`default_nettype wire
